// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for the RGB LED. A colour is accepted into a shadow
// register over valid/ready and copied to the active duty only at a frame boundary.
module rgb_pwm_driver #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                frame_start,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic                fs_q, fs_d;
  logic                tick;
  logic                wrap;
  logic                accept;

  logic [3*PWM_BITS-1:0] duty_all;
  logic [2:0]            led_vec;

  assign duty_all = {duty_b, duty_g, duty_r};

  always_comb begin
    tick      = (pre_q == PRE_MAX);
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d     = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
    wrap      = tick && (cnt_q == '1);
    accept    = duty_valid && !pending_q;
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (wrap) begin
      pending_d = 1'b0;
    end
    fs_d = (pre_d == '0) && (cnt_d == '0);
  end

  // The state right after reset is the frame origin, so the pulse register is
  // primed high and masked while rst is still asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      fs_q      <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      fs_q      <= fs_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [PWM_BITS-1:0] shadow_q, shadow_d;
      logic [PWM_BITS-1:0] active_q, active_d;
      logic                led_q, led_d;

      always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (accept) begin
          shadow_d = duty_all[gi*PWM_BITS +: PWM_BITS];
        end
        // accept and apply are exclusive: accept needs pending low, apply needs it high
        if (wrap && pending_q) begin
          active_d = shadow_q;
        end
        led_d = (cnt_q < active_q) ^ ACTIVE_LOW;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= '0;
          active_q <= '0;
          led_q    <= ACTIVE_LOW;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
          led_q    <= led_d;
        end
      end

      assign led_vec[gi] = led_q;
    end
  endgenerate

  assign duty_ready  = !pending_q;
  assign frame_start = fs_q && !rst;
  assign led_r       = led_vec[0];
  assign led_g       = led_vec[1];
  assign led_b       = led_vec[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Randomised bench for rgb_pwm_driver: two instances (active-low and active-high pins)
// checked every cycle against a frame-position model of the double-buffered duty.
module tb_rgb_pwm_driver;

  localparam int PB    = 4;
  localparam int PS    = 2;
  localparam int FRAME = PS * (1 << PB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          duty_valid = 1'b0;
  logic [PB-1:0] duty_r = '0;
  logic [PB-1:0] duty_g = '0;
  logic [PB-1:0] duty_b = '0;

  logic ready_l, fs_l, lr_l, lg_l, lb_l;
  logic ready_h, fs_h, lr_h, lg_h, lb_h;

  rgb_pwm_driver #(.PWM_BITS(PB), .PRESCALE(PS), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst(rst),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(ready_l), .frame_start(fs_l),
    .led_r(lr_l), .led_g(lg_l), .led_b(lb_l)
  );

  rgb_pwm_driver #(.PWM_BITS(PB), .PRESCALE(PS), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst(rst),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(ready_h), .frame_start(fs_h),
    .led_r(lr_h), .led_g(lg_h), .led_b(lb_h)
  );

  always #5 clk = ~clk;

  logic [2:0] led_lo, led_hi;
  assign led_lo = {lb_l, lg_l, lr_l};
  assign led_hi = {lb_h, lg_h, lr_h};

  int n_vec = 0;
  int n_err = 0;

  // Model: k = cycles since reset release; the frame position is k mod FRAME.
  int k = 0;
  int m_shadow [3];
  int m_active [3];
  bit m_pending;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  // A channel is lit for active*PS cycles starting one cycle into the frame.
  function automatic bit exp_lit(input int ch);
    int p;
    p = k % FRAME;
    return (p >= 1) && ((p - 1) < m_active[ch] * PS);
  endfunction

  task automatic check_cycle();
    int p;
    p = k % FRAME;
    check_eq("frame_start_lo", fs_l, (p == 0));
    check_eq("frame_start_hi", fs_h, (p == 0));
    check_eq("ready_lo", ready_l, !m_pending);
    check_eq("ready_hi", ready_h, !m_pending);
    for (int ch = 0; ch < 3; ch++) begin
      check_eq($sformatf("led%0d_lo", ch), led_lo[ch], !exp_lit(ch));
      check_eq($sformatf("led%0d_hi", ch), led_hi[ch], exp_lit(ch));
    end
  endtask

  task automatic step(input bit v, input int r, input int g, input int b);
    bit was_pending;
    check_cycle();
    duty_valid = v;
    duty_r     = PB'(r);
    duty_g     = PB'(g);
    duty_b     = PB'(b);
    was_pending = m_pending;
    if ((k % FRAME == FRAME - 1) && was_pending) begin
      for (int ch = 0; ch < 3; ch++) m_active[ch] = m_shadow[ch];
      m_pending = 1'b0;
    end
    if (v && !was_pending) begin
      m_shadow[0] = r;
      m_shadow[1] = g;
      m_shadow[2] = b;
      m_pending   = 1'b1;
      $display("cycle %0d pos %0d: accept r=%0d g=%0d b=%0d", k, k % FRAME, r, g, b);
    end else if (v) begin
      $display("cycle %0d pos %0d: busy, colour r=%0d g=%0d b=%0d dropped", k, k % FRAME, r, g, b);
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    duty_valid = 1'b1;
    duty_r     = PB'($urandom_range(0, 15));
    duty_g     = PB'($urandom_range(0, 15));
    duty_b     = PB'($urandom_range(0, 15));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_leds_lo", led_lo, 3'b111);
      check_eq("rst_leds_hi", led_hi, 3'b000);
      check_eq("rst_ready_lo", ready_l, 1'b1);
      check_eq("rst_ready_hi", ready_h, 1'b1);
      check_eq("rst_fs_lo", fs_l, 1'b0);
      check_eq("rst_fs_hi", fs_h, 1'b0);
    end
    rst        = 1'b0;
    duty_valid = 1'b0;
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      m_shadow[ch] = 0;
      m_active[ch] = 0;
    end
    m_pending = 1'b0;
    k = 0;
    $display("reset released after %0d cycles", n);
  endtask

  // Advance until the next frame-boundary cycle with nothing pending.
  task automatic goto_wrap();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ((k % FRAME == FRAME - 1) && !m_pending) break;
      idle(1);
    end
  endtask

  initial begin
    do_reset(2);

    // Single load, then the pattern must repeat untouched.
    step(1'b1, 4, 0, 15);
    idle(3 * FRAME);

    // Back-to-back: the second colour is dropped while busy.
    idle(5);
    step(1'b1, 2, 7, 1);
    idle(2 * FRAME);
    step(1'b1, 4, 3, 8);
    step(1'b1, 9, 9, 9);
    idle(2 * FRAME);

    // Accept exactly in the boundary cycle: applied one frame later.
    goto_wrap();
    step(1'b1, 6, 11, 0);
    idle(3 * FRAME);

    // Best case: accept one cycle before the boundary.
    goto_wrap();
    idle(FRAME - 1);
    step(1'b1, 13, 1, 5);
    idle(2 * FRAME);

    // Reset mid-frame with r=10 active and another colour pending.
    step(1'b1, 10, 5, 2);
    idle(2 * FRAME);
    idle(7);
    step(1'b1, 3, 3, 3);
    idle(4);
    do_reset(1);
    idle(2 * FRAME);

    // Random traffic with an occasional reset.
    for (int i = 0; i < 640; i++) begin
      if (i == 333) begin
        do_reset($urandom_range(1, 3));
      end
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
    end
    idle(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
